mem_cache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate cache controller that sits directly upstream of the main data memory. The processor control unit issues load/store requests to this block. On a hit, reads are served locally. On a miss, and for every write, the block drives the memory's read/write/address/data lines and waits for the memory's Done pulse. A timeout guards against a memory that never answers.

---
 rtl/mem_cache_ctrl_pkg.sv | 25 ++
 rtl/mem_cache_ctrl_cache_line_array.sv | 52 +++++
 rtl/mem_cache_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mem_cache_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_cache_ctrl_pkg
// Purpose  : Shared state encoding and memory-geometry constants for the
//            direct-mapped write-through cache controller.
// Revision : 1.0  initial release
// ============================================================================
package mem_cache_ctrl_pkg;

    // Geometry shared with the main data memory
    localparam int C_ADDR_W  = 13;
    localparam int C_DATA_W  = 13;
    localparam int C_LINES   = 4;
    // Cycles to wait for mem_done before reporting an error
    localparam int C_TIMEOUT = 15;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MEM_RD = 2'd1,
        S_MEM_WR = 2'd2,
        S_RESP   = 2'd3
    } state_e;

endpackage : mem_cache_ctrl_pkg
`default_nettype wire

// File: rtl/mem_cache_ctrl_cache_line_array.sv
`default_nettype none
// ============================================================================
// Module   : cache_line_array
// Purpose  : Valid/tag/data storage for a direct-mapped cache. Combinational
//            lookup, one synchronous write/fill port, whole-array invalidate.
// Revision : 1.0  initial release
// ============================================================================
module cache_line_array #(
    parameter int LINES   = 4,
    parameter int INDEX_W = 2,
    parameter int TAG_W   = 11,
    parameter int DATA_W  = 13
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] lu_index_i,
    input  logic [TAG_W-1:0]   lu_tag_i,
    output logic               hit_o,
    output logic [DATA_W-1:0]  rdata_o,
    input  logic               flush_i,
    input  logic               we_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [DATA_W-1:0]  wr_data_i
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    assign hit_o   = valid_q[lu_index_i] && (tag_q[lu_index_i] == lu_tag_i);
    assign rdata_o = data_q[lu_index_i];

    // Valid bits: cleared by reset or flush, set by any write to a line
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag/data storage is deliberately left uninitialised; valid gates it
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

endmodule : cache_line_array
`default_nettype wire

// File: rtl/mem_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_cache_ctrl
// Purpose  : Direct-mapped, write-through, no-write-allocate cache controller
//            in front of main memory, with a bounded wait on mem_done.
// Revision : 1.0  initial release
// ============================================================================
module mem_cache_ctrl
    import mem_cache_ctrl_pkg::*;
#(
    parameter int ADDR_W  = C_ADDR_W,
    parameter int DATA_W  = C_DATA_W,
    parameter int LINES   = C_LINES,
    parameter int TIMEOUT = C_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_ready_o,
    output logic              cpu_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_done_i
);

    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = ADDR_W - INDEX_W;
    localparam int CNT_W   = $clog2(TIMEOUT + 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              err_q;
    logic              ready_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [DATA_W-1:0] mwdata_q;
    logic              mread_q;
    logic              mwrite_q;

    logic              lu_hit;
    logic [DATA_W-1:0] lu_rdata;
    logic              arr_flush;
    logic              arr_we;
    logic [INDEX_W-1:0] arr_index;
    logic [TAG_W-1:0]  arr_tag;
    logic [DATA_W-1:0] arr_data;
    logic              new_req;
    logic              timeout_hit;

    // A request is only accepted in IDLE when no flush competes with it
    assign new_req     = (state_q == S_IDLE) && !flush_i && cpu_req_i;
    assign cnt_d       = cnt_q + 1'b1;
    assign timeout_hit = (cnt_d == CNT_W'(TIMEOUT));

    assign cpu_rdata_o = rdata_q;
    assign cpu_ready_o = ready_q;
    assign cpu_err_o   = err_q;
    assign mem_addr_o  = maddr_q;
    assign mem_wdata_o = mwdata_q;
    assign mem_read_o  = mread_q;
    assign mem_write_o = mwrite_q;

    cache_line_array #(
        .LINES   (LINES),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_lines (
        .clk        (clk),
        .reset      (reset),
        .lu_index_i (cpu_addr_i[INDEX_W-1:0]),
        .lu_tag_i   (cpu_addr_i[ADDR_W-1:INDEX_W]),
        .hit_o      (lu_hit),
        .rdata_o    (lu_rdata),
        .flush_i    (arr_flush),
        .we_i       (arr_we),
        .wr_index_i (arr_index),
        .wr_tag_i   (arr_tag),
        .wr_data_i  (arr_data)
    );

    // Array write port: store-hit update from IDLE, or line fill on read done
    always_comb begin
        arr_flush = (state_q == S_IDLE) && flush_i;
        arr_we    = 1'b0;
        arr_index = cpu_addr_i[INDEX_W-1:0];
        arr_tag   = cpu_addr_i[ADDR_W-1:INDEX_W];
        arr_data  = cpu_wdata_i;
        if (new_req && cpu_we_i && lu_hit) begin
            arr_we = !reset;
        end else if ((state_q == S_MEM_RD) && mem_done_i) begin
            arr_we    = !reset;
            arr_index = maddr_q[INDEX_W-1:0];
            arr_tag   = maddr_q[ADDR_W-1:INDEX_W];
            arr_data  = mem_rdata_i;
        end
    end

    // Controller FSM with registered CPU and memory-side outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mread_q  <= 1'b0;
            mwrite_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (new_req) begin
                        maddr_q  <= cpu_addr_i;
                        mwdata_q <= cpu_wdata_i;
                        if (cpu_we_i) begin
                            mwrite_q <= 1'b1;
                            state_q  <= S_MEM_WR;
                        end else if (lu_hit) begin
                            rdata_q <= lu_rdata;
                            ready_q <= 1'b1;
                            state_q <= S_RESP;
                        end else begin
                            mread_q <= 1'b1;
                            state_q <= S_MEM_RD;
                        end
                    end
                end
                S_MEM_RD, S_MEM_WR: begin
                    cnt_q <= cnt_d;
                    if (mem_done_i) begin
                        mread_q  <= 1'b0;
                        mwrite_q <= 1'b0;
                        ready_q  <= 1'b1;
                        if (state_q == S_MEM_RD) begin
                            rdata_q <= mem_rdata_i;
                        end
                        state_q <= S_RESP;
                    end else if (timeout_hit) begin
                        mread_q  <= 1'b0;
                        mwrite_q <= 1'b0;
                        ready_q  <= 1'b1;
                        err_q    <= 1'b1;
                        rdata_q  <= '0;
                        state_q  <= S_RESP;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule : mem_cache_ctrl
`default_nettype wire

// File: tb/tb_mem_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_cache_ctrl
// Purpose  : Self-checking bench for mem_cache_ctrl: directed vector table,
//            multi-cycle corner sequences and randomized accesses against a
//            behavioural cache/memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_cache_ctrl;

    localparam int AW = 13;
    localparam int DW = 13;
    localparam int NLINES = 4;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req_i, cpu_we_i, flush_i;
    logic [AW-1:0] cpu_addr_i;
    logic [DW-1:0] cpu_wdata_i;
    logic [DW-1:0] cpu_rdata_o;
    logic          cpu_ready_o, cpu_err_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_write_o, mem_read_o;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_done_i;

    always #5 clk = ~clk;

    mem_cache_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .flush_i     (flush_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_ready_o (cpu_ready_o),
        .cpu_err_o   (cpu_err_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_write_o (mem_write_o),
        .mem_read_o  (mem_read_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_done_i  (mem_done_i)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Memory seen by the DUT, and the model's view of what it should hold
    logic [DW-1:0] dut_mem [1 << AW];
    logic [DW-1:0] ref_mem [1 << AW];

    // Model cache state, kept as plain integers per line
    bit m_valid [NLINES];
    int m_tag   [NLINES];
    int m_data  [NLINES];

    // kind: 0 = no memory access, 1 = read, 2 = write, 3 = both (illegal)
    typedef struct {
        bit       seen;
        int       kind;
        int       maddr;
        int       mwdata;
        int       rdata;
        int       err;
        int       cyc;
    } obs_t;

    typedef struct {
        int kind;
        int maddr;
        int mwdata;
        int rdata;
        int err;
        int cyc;
    } exp_t;

    // lat = number of request cycles before mem_done; 0 means never answer
    typedef struct {
        bit we;
        int addr;
        int wdata;
        int lat;
        bit fl;
        bit preset;
        int pval;
        exp_t e;
    } vec_t;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NLINES; i++) m_valid[i] = 1'b0;
    endfunction

    // Expected outcome of one access computed from the cache rules, then the
    // model state is advanced as the access would leave it.
    function automatic exp_t model_step(input bit we, input int a, input int wd,
                                        input int lat, input bit fl);
        exp_t e;
        int   idx, tg, extra;
        bit   hit, ok;
        if (fl) model_reset();
        idx   = a % NLINES;
        tg    = a / NLINES;
        hit   = m_valid[idx] && (m_tag[idx] == tg);
        ok    = (lat != 0);
        extra = fl ? 1 : 0;
        e     = '{default: 0};
        if (!we && hit) begin
            e.kind  = 0;
            e.rdata = m_data[idx];
            e.cyc   = 1 + extra;
        end else begin
            e.kind   = we ? 2 : 1;
            e.maddr  = a;
            e.mwdata = wd;
            e.err    = ok ? 0 : 1;
            e.cyc    = (ok ? lat + 1 : TMO + 1) + extra;
            if (!we) begin
                e.rdata = ok ? int'(ref_mem[a]) : 0;
                if (ok) begin
                    m_valid[idx] = 1'b1;
                    m_tag[idx]   = tg;
                    m_data[idx]  = int'(ref_mem[a]);
                end
            end else begin
                if (hit) m_data[idx] = wd;
                if (ok) ref_mem[a] = DW'(wd);
            end
        end
        return e;
    endfunction

    // Issue one CPU request, act as the main memory, and record what happened
    task automatic run_access(input bit we, input int a, input int wd,
                              input int lat, input bit fl, output obs_t o);
        int nreq;
        o    = '{default: 0};
        nreq = 0;
        @(negedge clk);
        cpu_req_i   = 1'b1;
        cpu_we_i    = we;
        cpu_addr_i  = AW'(a);
        cpu_wdata_i = DW'(wd);
        flush_i     = fl;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (fl && c == 1) begin
                check("flush_ignores_req", int'({mem_read_o, mem_write_o, cpu_ready_o}), 0);
                flush_i = 1'b0;
            end
            mem_done_i  = 1'b0;
            mem_rdata_i = DW'($urandom);
            if (mem_read_o || mem_write_o) begin
                if (nreq == 0) begin
                    o.maddr  = int'(mem_addr_o);
                    o.mwdata = int'(mem_wdata_o);
                end
                o.kind = o.kind | int'({mem_write_o, mem_read_o});
                nreq++;
                if (lat != 0 && nreq == lat) begin
                    mem_done_i = 1'b1;
                    if (mem_write_o) dut_mem[mem_addr_o] = mem_wdata_o;
                    else             mem_rdata_i = dut_mem[mem_addr_o];
                end
            end
            if (cpu_ready_o) begin
                o.seen  = 1'b1;
                o.cyc   = c;
                o.rdata = int'(cpu_rdata_o);
                o.err   = int'(cpu_err_o);
                cpu_req_i = 1'b0;
                break;
            end
        end
        cpu_req_i  = 1'b0;
        mem_done_i = 1'b0;
        flush_i    = 1'b0;
        check("ready_within_bound", int'(o.seen), 1);
        if (o.seen) begin
            @(negedge clk);
            check("ready_single_pulse", int'(cpu_ready_o), 0);
        end
    endtask

    task automatic compare(input string tag, input bit we, input obs_t o, input exp_t e);
        check({tag, ".kind"}, o.kind, e.kind);
        if (e.kind != 0) check({tag, ".mem_addr"}, o.maddr, e.maddr);
        if (we) check({tag, ".mem_wdata"}, o.mwdata, e.mwdata);
        else    check({tag, ".rdata"}, o.rdata, e.rdata);
        check({tag, ".err"}, o.err, e.err);
        check({tag, ".cycles"}, o.cyc, e.cyc);
    endtask

    vec_t vecs [9];
    obs_t ob;
    exp_t ex;

    initial begin
        // Directed scenario; expected values derived by hand from the cache rules
        //          we  addr   wdata  lat fl pre pval     kind maddr mwd   rdata  err cyc
        vecs[0] = '{0, 'h005, 0,     2,  0, 1, 'h1AB, '{1, 'h005, 0,     'h1AB, 0, 3}};
        vecs[1] = '{0, 'h005, 0,     1,  0, 0, 0,     '{0, 0,     0,     'h1AB, 0, 1}};
        vecs[2] = '{1, 'h005, 'h0FF, 1,  0, 0, 0,     '{2, 'h005, 'h0FF, 0,     0, 2}};
        vecs[3] = '{0, 'h005, 0,     1,  0, 0, 0,     '{0, 0,     0,     'h0FF, 0, 1}};
        vecs[4] = '{0, 'h009, 0,     3,  0, 1, 'h777, '{1, 'h009, 0,     'h777, 0, 4}};
        vecs[5] = '{0, 'h005, 0,     1,  0, 0, 0,     '{1, 'h005, 0,     'h0FF, 0, 2}};
        vecs[6] = '{0, 'h003, 0,     0,  0, 0, 0,     '{1, 'h003, 0,     0,     1, 16}};
        vecs[7] = '{0, 'h003, 0,     1,  0, 1, 'h123, '{1, 'h003, 0,     'h123, 0, 2}};
        vecs[8] = '{0, 'h005, 0,     1,  1, 0, 0,     '{1, 'h005, 0,     'h0FF, 0, 3}};

        for (int i = 0; i < (1 << AW); i++) begin
            dut_mem[i] = DW'($urandom);
            ref_mem[i] = dut_mem[i];
        end
        model_reset();

        reset = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; flush_i = 1'b0;
        cpu_addr_i = '0; cpu_wdata_i = '0; mem_rdata_i = '0; mem_done_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.cpu_ready", int'(cpu_ready_o), 0);
        check("rst.cpu_err",   int'(cpu_err_o),   0);
        check("rst.cpu_rdata", int'(cpu_rdata_o), 0);
        check("rst.mem_read",  int'(mem_read_o),  0);
        check("rst.mem_write", int'(mem_write_o), 0);
        check("rst.mem_addr",  int'(mem_addr_o),  0);
        check("rst.mem_wdata", int'(mem_wdata_o), 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].preset) begin
                dut_mem[vecs[i].addr] = DW'(vecs[i].pval);
                ref_mem[vecs[i].addr] = DW'(vecs[i].pval);
            end
            ex = model_step(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].lat, vecs[i].fl);
            run_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].lat, vecs[i].fl, ob);
            compare($sformatf("vec%0d", i), vecs[i].we, ob, vecs[i].e);
        end

        // Reset while a load is waiting on memory: aborted, no fill, no ready
        @(negedge clk);
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = AW'('h00D);
        ob.seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_read_o) begin ob.seen = 1'b1; break; end
        end
        check("rst_mid.read_started", int'(ob.seen), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1; cpu_req_i = 1'b0;
        @(negedge clk);
        check("rst_mid.mem_read", int'(mem_read_o), 0);
        check("rst_mid.cpu_ready", int'(cpu_ready_o), 0);
        reset = 1'b0;
        ob.cyc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ob.cyc = ob.cyc | int'(cpu_ready_o) | int'(mem_read_o);
        end
        check("rst_mid.quiet_after", ob.cyc, 0);
        model_reset();
        ex = model_step(0, 'h005, 0, 2, 0);
        run_access(0, 'h005, 0, 2, 0, ob);
        compare("post_rst_load", 0, ob, ex);

        // Randomized accesses against the behavioural model
        for (int i = 0; i < 60; i++) begin
            bit rwe, rfl;
            int ra, rwd, rlat;
            rwe  = ($urandom_range(0, 2) == 0);
            ra   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, (1 << AW) - 1))
                                               : int'($urandom_range(0, 15));
            rwd  = int'($urandom_range(0, (1 << DW) - 1));
            rlat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
            rfl  = ($urandom_range(0, 11) == 0);
            ex = model_step(rwe, ra, rwd, rlat, rfl);
            run_access(rwe, ra, rwd, rlat, rfl, ob);
            compare($sformatf("rnd%0d", i), rwe, ob, ex);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mem_cache_ctrl
`default_nettype wire
